// File: rtl/ising_run_ctrl_if.sv
// Memory-mapped write/read bus shared by core_matrix and the run sequencer.
// The manager drives the write strobe, addresses and write data; rdata returns.
interface ising_run_ctrl_if;
  logic        wready;
  logic [31:0] wr_addr;
  logic [31:0] wdata;
  logic [31:0] rd_addr;
  logic [31:0] rdata;

  modport master (
    output wready,
    output wr_addr,
    output wdata,
    output rd_addr,
    input  rdata
  );

  modport slave (
    input  wready,
    input  wr_addr,
    input  wdata,
    input  rd_addr,
    output rdata
  );
endinterface

// File: rtl/ising_run_ctrl.sv
// Run sequencer for the coupled-oscillator matrix: hold in reset, anneal, phase-vote sample.
// Optional RUNCYC busy-cycle counter at offset 0x18 when RUN_CYCLE_COUNT_EN is defined.
`ifndef CTRL_ADDR_MASK
`define CTRL_ADDR_MASK 8'h40
`endif

module ising_run_ctrl #(
  parameter int unsigned N        = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ANNEAL_W = 32
) (
  input  logic                 clk,
  input  logic                 axi_rst,
  ising_run_ctrl_if.slave      bus,
  input  logic [N-1:0]         osc_in,
  output logic                 ising_rstn,
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0]         result
);

  typedef enum logic [2:0] {StIdle, StHold, StAnneal, StSample, StDone} state_e;

  state_e              state_q;
  logic [ANNEAL_W-1:0] cnt_q;
  logic [CNT_W-1:0]    hold_q;
  logic [ANNEAL_W-1:0] anneal_q;
  logic [CNT_W-1:0]    sample_q;
  logic [CNT_W-1:0]    agree_q [N];
  logic [N-1:0]        sync1_q, sync2_q;
  logic [N-1:0]        result_q;
  logic                result_valid_q, done_sticky_q, done_q, rstn_q;
`ifdef RUN_CYCLE_COUNT_EN
  logic [31:0]         runcyc_q;
`endif

  logic                wr_sel, wr_ctrl, start, abort, cfg_we;
  logic [7:0]          wr_off;
  logic [ANNEAL_W-1:0] hold_ld, anneal_ld, sample_ld;
  logic [CNT_W-1:0]    sample_n;
  logic [N-1:0]        vote;
  logic                unused_bus;

  assign wr_sel  = bus.wready && (bus.wr_addr[31:24] == `CTRL_ADDR_MASK);
  assign wr_off  = bus.wr_addr[7:0];
  assign wr_ctrl = wr_sel && (wr_off == 8'h00);
  assign abort   = wr_ctrl && bus.wdata[1];
  // Abort and start in one write: abort wins.
  assign start   = wr_ctrl && bus.wdata[0] && !bus.wdata[1];
  assign cfg_we  = wr_sel && (state_q == StIdle);

  // A programmed length of zero runs as a single cycle.
  assign sample_n  = (sample_q == '0) ? CNT_W'(1) : sample_q;
  assign hold_ld   = (hold_q == '0) ? ANNEAL_W'(1) : ANNEAL_W'(hold_q);
  assign anneal_ld = (anneal_q == '0) ? ANNEAL_W'(1) : anneal_q;
  assign sample_ld = ANNEAL_W'(sample_n);

  assign unused_bus = ^{bus.wr_addr[23:8], bus.rd_addr[23:8], bus.wdata};

  always_comb begin
    vote = '0;
    for (int i = 0; i < int'(N); i++) begin
      vote[i] = {agree_q[i], 1'b0} > {1'b0, sample_n};
    end
    vote[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      hold_q         <= CNT_W'(16);
      anneal_q       <= ANNEAL_W'(1000);
      sample_q       <= CNT_W'(64);
      sync1_q        <= '0;
      sync2_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      done_sticky_q  <= 1'b0;
      done_q         <= 1'b0;
      rstn_q         <= 1'b0;
      for (int i = 0; i < int'(N); i++) agree_q[i] <= '0;
`ifdef RUN_CYCLE_COUNT_EN
      runcyc_q       <= '0;
`endif
    end else begin
      sync1_q <= osc_in;
      sync2_q <= sync1_q;
      done_q  <= 1'b0;

      if (cfg_we) begin
        case (wr_off)
          8'h04:   hold_q   <= bus.wdata[CNT_W-1:0];
          8'h08:   anneal_q <= bus.wdata[ANNEAL_W-1:0];
          8'h0C:   sample_q <= bus.wdata[CNT_W-1:0];
          default: ;
        endcase
      end

`ifdef RUN_CYCLE_COUNT_EN
      if (state_q != StIdle && runcyc_q != '1) runcyc_q <= runcyc_q + 32'd1;
`endif

      if (abort && state_q != StIdle) begin
        state_q <= StIdle;
        rstn_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q       <= StHold;
              cnt_q         <= hold_ld;
              done_sticky_q <= 1'b0;
`ifdef RUN_CYCLE_COUNT_EN
              runcyc_q      <= '0;
`endif
            end
          end
          StHold: begin
            if (cnt_q == ANNEAL_W'(1)) begin
              state_q <= StAnneal;
              cnt_q   <= anneal_ld;
              rstn_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - ANNEAL_W'(1);
            end
          end
          StAnneal: begin
            if (cnt_q == ANNEAL_W'(1)) begin
              state_q <= StSample;
              cnt_q   <= sample_ld;
              for (int i = 0; i < int'(N); i++) agree_q[i] <= '0;
            end else begin
              cnt_q <= cnt_q - ANNEAL_W'(1);
            end
          end
          StSample: begin
            for (int i = 0; i < int'(N); i++) begin
              if (sync2_q[i] == sync2_q[0] && agree_q[i] != '1) begin
                agree_q[i] <= agree_q[i] + CNT_W'(1);
              end
            end
            if (cnt_q == ANNEAL_W'(1)) begin
              state_q <= StDone;
              rstn_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - ANNEAL_W'(1);
            end
          end
          StDone: begin
            result_q       <= vote;
            result_valid_q <= 1'b1;
            done_sticky_q  <= 1'b1;
            done_q         <= 1'b1;
            state_q        <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy       = (state_q != StIdle);
  assign ising_rstn = rstn_q;
  assign done       = done_q;
  assign result     = result_q;

  always_comb begin
    bus.rdata = '0;
    if (bus.rd_addr[31:24] == `CTRL_ADDR_MASK) begin
      case (bus.rd_addr[7:0])
        8'h04:   bus.rdata = 32'(hold_q);
        8'h08:   bus.rdata = 32'(anneal_q);
        8'h0C:   bus.rdata = 32'(sample_q);
        8'h10:   bus.rdata = {29'b0, result_valid_q, done_sticky_q, busy};
        8'h14:   bus.rdata = 32'(result_q);
`ifdef RUN_CYCLE_COUNT_EN
        8'h18:   bus.rdata = runcyc_q;
`endif
        default: bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Bench for ising_run_ctrl: directed and randomized runs checked against a per-run
// arithmetic model of phase agreement and cycle timing.
`ifndef CTRL_ADDR_MASK
`define CTRL_ADDR_MASK 8'h40
`endif

module tb_ising_run_ctrl;
  logic       clk = 1'b0;
  logic       axi_rst;
  logic [7:0] osc_in;
  logic       ising_rstn, busy, done;
  logic [7:0] result;

  always #5 clk = ~clk;

  ising_run_ctrl_if bus ();

  ising_run_ctrl #(.N(8), .CNT_W(16), .ANNEAL_W(32)) dut (
    .clk        (clk),
    .axi_rst    (axi_rst),
    .bus        (bus),
    .osc_in     (osc_in),
    .ising_rstn (ising_rstn),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  localparam logic [31:0] Base = {`CTRL_ADDR_MASK, 24'h0};

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_result;
  logic        exp_valid;
  logic [7:0]  pat [256];
  logic [31:0] rv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    bus.wready  = 1'b1;
    bus.wr_addr = Base | 32'(off);
    bus.wdata   = d;
    tick();
    bus.wready  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    bus.rd_addr = Base | 32'(off);
    #1;
    d = bus.rdata;
  endtask

  // mode: 0 random, 1 phase split, 2 tie on bit1, 3 all ones
  task automatic run_case(input int h, input int a, input int s, input int mode,
                          input int abort_at, input bit guard);
    int         he, ae, se, tot, cnt;
    logic [7:0] model;
    bit         aborted;
    wr(8'h04, 32'(h));
    wr(8'h08, 32'(a));
    wr(8'h0C, 32'(s));
    he  = (h == 0) ? 1 : h;
    ae  = (a == 0) ? 1 : a;
    se  = (s == 0) ? 1 : s;
    tot = he + ae + se;
    for (int k = 0; k < 256; k++) begin
      case (mode)
        0:       pat[k] = 8'($urandom);
        1:       pat[k] = k[0] ? 8'h0F : 8'hF0;
        2:       pat[k] = k[1] ? 8'h02 : 8'h00;
        default: pat[k] = 8'hFF;
      endcase
    end
    // Vote window: samples see osc_in two edges late through the synchronizer.
    model = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = 0;
      for (int k = he + ae - 1; k <= he + ae + se - 2; k++) begin
        if (pat[k][i] == pat[k][0]) cnt++;
      end
      model[i] = (2 * cnt > se);
    end

    osc_in      = pat[0];
    bus.wready  = 1'b1;
    bus.wr_addr = Base;
    bus.wdata   = 32'h1;
    tick();
    bus.wready  = 1'b0;
    aborted     = 1'b0;
    for (int k = 0; k <= tot + 2; k++) begin
      aborted = (abort_at >= 0) && (k > abort_at);
      check($sformatf("busy@%0d", k), 32'(busy), 32'(!aborted && k <= tot));
      check($sformatf("rstn@%0d", k), 32'(ising_rstn),
            32'(!aborted && k >= he && k <= tot - 1));
      check($sformatf("done@%0d", k), 32'(done), 32'(!aborted && k == tot + 1));
      osc_in = pat[k + 1];
      if (k == abort_at) begin
        bus.wready = 1'b1; bus.wr_addr = Base; bus.wdata = 32'h3;
      end else if (guard && k == 1) begin
        bus.wready = 1'b1; bus.wr_addr = Base; bus.wdata = 32'h1;
      end else if (guard && k == 2) begin
        bus.wready = 1'b1; bus.wr_addr = Base | 32'h04; bus.wdata = 32'd7;
      end
      tick();
      bus.wready = 1'b0;
    end

    if (!aborted) begin
      exp_result = model;
      exp_valid  = 1'b1;
    end
    check("result_port", 32'(result), 32'(exp_result));
    rd(8'h14, rv);
    check("result_reg", rv, 32'(exp_result));
    rd(8'h10, rv);
    check("status", rv, {29'b0, exp_valid, !aborted, 1'b0});
    if (guard) begin
      rd(8'h04, rv);
      check("hold_guard", rv, 32'(h));
    end
  endtask

  initial begin
    axi_rst     = 1'b1;
    osc_in      = '0;
    bus.wready  = 1'b0;
    bus.wr_addr = '0;
    bus.wdata   = '0;
    bus.rd_addr = Base;
    exp_result  = '0;
    exp_valid   = 1'b0;
    tick();
    tick();
    axi_rst = 1'b0;

    rd(8'h04, rv); check("rst_hold", rv, 32'd16);
    rd(8'h08, rv); check("rst_anneal", rv, 32'd1000);
    rd(8'h0C, rv); check("rst_sample", rv, 32'd64);
    rd(8'h10, rv); check("rst_status", rv, 32'd0);
    rd(8'h00, rv); check("ctrl_reads0", rv, 32'd0);
    check("rst_rstn", 32'(ising_rstn), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Timing run: 3 hold, 5 anneal, 4 samples of an all-ones pattern.
    run_case(3, 5, 4, 3, -1, 1'b0);
    check("timing_result", 32'(result), 32'hFF);
    rd(8'h10, rv); check("timing_status", rv, 32'h6);
`ifdef RUN_CYCLE_COUNT_EN
    rd(8'h18, rv); check("runcyc", rv, 32'd13);
`else
    rd(8'h18, rv); check("runcyc_absent", rv, 32'd0);
`endif
    rd(8'h1C, rv); check("unmapped", rv, 32'd0);
    bus.rd_addr = {~`CTRL_ADDR_MASK, 24'h000004};
    #1;
    check("bad_mask", bus.rdata, 32'd0);

    run_case(2, 3, 8, 1, -1, 1'b0);
    check("phase_vote", 32'(result), 32'h0F);

    run_case(1, 2, 4, 2, -1, 1'b0);
    check("tie_rule", 32'(result), 32'hFD);

    // Abort mid-anneal keeps the last result, then a fresh run completes.
    run_case(3, 100, 4, 0, 20, 1'b0);
    run_case(3, 5, 4, 1, -1, 1'b0);

    run_case(4, 6, 5, 0, -1, 1'b1);
    run_case(0, 2, 3, 0, -1, 1'b0);
    run_case(1, 0, 0, 0, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      run_case(int'($urandom_range(0, 5)), int'($urandom_range(0, 8)),
               int'($urandom_range(0, 9)), 0, -1, 1'b0);
    end

    // Reset in the middle of a run returns everything to defaults.
    wr(8'h00, 32'h1);
    tick();
    tick();
    axi_rst = 1'b1;
    tick();
    axi_rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rstn", 32'(ising_rstn), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    rd(8'h04, rv); check("midrst_hold", rv, 32'd16);
    rd(8'h10, rv); check("midrst_status", rv, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
